// File: rtl/arb_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
// Optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  localparam int NREQ = 16;
  localparam int IDW  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NREQ-1:0] rot_r16(
    input logic [NREQ-1:0] vec,
    input logic [IDW-1:0]  sh
  );
    logic [2*NREQ-1:0] dbl;
    dbl = {vec, vec} >> sh;
    return dbl[NREQ-1:0];
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16->4 priority encoder.
// Returns the index of the lowest set bit plus a valid flag.
module prio_enc16
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] in,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = |in;
    // scan high to low so the lowest set bit wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (in[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter, 16 requesters, grant held until request drops.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module rr_arb16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  localparam int CNT_W   = $clog2(MAX_HOLD) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  arb_state_t      state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] req_rot;
  logic [IDW-1:0]  enc_idx;
  logic            enc_valid;
  logic [IDW-1:0]  win;
  logic            held;
  logic            to_hit;

  assign req_rot = rot_r16(req, ptr);

  prio_enc16 u_enc (
    .in    (req_rot),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // undo the rotation in mod-16 arithmetic
  assign win  = enc_idx + ptr;
  assign held = req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  assign to_hit = held && (hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= enc_valid ? CNT_W'(1) : '0;
    end else if (!held || to_hit) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_HOLD[0], CNT_W[0]};
  assign to_hit     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enc_valid) begin
            gnt       <= NREQ'(1) << win;
            gnt_id    <= win;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!held || to_hit) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + IDW'(1);
            state     <= IDLE;
            timeout   <= held;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb16.sv
// Directed self-checking bench for rr_arb16.
// Timeout steps run only when ARB_TIMEOUT_EN is defined.
module tb_rr_arb16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arb16 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] eg,
                         input logic [3:0] eid, input logic et);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".id"}, 16'(gnt_id), 16'(eid));
    chk({tag, ".valid"}, 16'(gnt_valid), 16'(eg != 16'h0));
    chk({tag, ".timeout"}, 16'(timeout), 16'(et));
  endtask

  initial begin
    rst = 1'b1;
    req = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("reset", 16'h0, 4'd0, 1'b0);
    end

    rst = 1'b0;
    req = 16'h0010;
    step();
    chk_out("single4", 16'h0010, 4'd4, 1'b0);
    req = 16'h0011;
    step();
    chk_out("hold4", 16'h0010, 4'd4, 1'b0);
    req = 16'h0000;
    step();
    chk_out("rel4", 16'h0, 4'd0, 1'b0);
    req = 16'h0021;
    step();
    chk_out("ptr5", 16'h0020, 4'd5, 1'b0);
    req = 16'h0000;
    step();
    chk_out("rel5", 16'h0, 4'd0, 1'b0);

    req = 16'h0004;
    #2 req = 16'h0000;
    step();
    chk_out("drop_idle", 16'h0, 4'd0, 1'b0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      req = 16'hFFFF;
      step();
      chk_out($sformatf("rr%0d", i), 16'(1) << (i % 16), 4'(i % 16), 1'b0);
      step();
      chk_out($sformatf("rrh%0d", i), 16'(1) << (i % 16), 4'(i % 16), 1'b0);
      req = 16'hFFFF & ~(16'(1) << (i % 16));
      step();
      chk_out($sformatf("rrd%0d", i), 16'h0, 4'd0, 1'b0);
    end

    req = 16'h2000;
    step();
    chk_out("g13", 16'h2000, 4'd13, 1'b0);
    req = 16'h0000;
    step();
    req = 16'h0003;
    step();
    chk_out("ptr14_wrap", 16'h0001, 4'd0, 1'b0);
    req = 16'h0000;
    step();

    req = 16'h4000;
    step();
    chk_out("g14", 16'h4000, 4'd14, 1'b0);
    req = 16'h0000;
    step();
    req = 16'h8001;
    step();
    chk_out("ptr15", 16'h8000, 4'd15, 1'b0);
    req = 16'h0001;
    step();
    chk_out("rel15", 16'h0, 4'd0, 1'b0);
    step();
    chk_out("after15", 16'h0001, 4'd0, 1'b0);
    req = 16'h0000;
    step();

    req = 16'h0080;
    step();
    chk_out("g7", 16'h0080, 4'd7, 1'b0);
    req = 16'h0000;
    step();
    chk_out("rel7", 16'h0, 4'd0, 1'b0);
    req = 16'h0080;
    step();
    chk_out("regrant7", 16'h0080, 4'd7, 1'b0);
    rst = 1'b1;
    step();
    chk_out("rst_mid", 16'h0, 4'd0, 1'b0);
    rst = 1'b0;
    req = 16'h0180;
    step();
    chk_out("ptr0_after_rst", 16'h0080, 4'd7, 1'b0);

`ifdef ARB_TIMEOUT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 16'h0008;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("to_hold%0d", i), 16'h0008, 4'd3, 1'b0);
    end
    req = 16'h000C;
    step();
    chk_out("to_revoke", 16'h0, 4'd0, 1'b1);
    step();
    chk_out("to_next", 16'h0004, 4'd2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
